// File: rtl/controller_multicycle.sv
// controller_multicycle: state sequencer for an RV32I-subset multicycle core
// (R-type, I-ALU, lw, sw, jal, jalr, beq, bne, lui) on a single-memory,
// single-ALU datapath.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   opcode, f3, zero        IR opcode/funct3 fields and ALU zero flag
//   pc_write, ir_write,
//   mem_write, reg_write    datapath write enables
//   adr_src, result_src,
//   alu_src_a, alu_src_b,
//   imm_src, alu_op         datapath mux selects / ALU decoder class
//   instr_done, illegal     last-cycle marker and unsupported-opcode flag
//   state                   current state code for debug
module controller_multicycle (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] f3,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EX_R      = 4'd6,
    S_EX_I      = 4'd7,
    S_ALU_WB    = 4'd8,
    S_JAL       = 4'd9,
    S_BRANCH    = 4'd10,
    S_LUI       = 4'd11,
    S_JALR      = 4'd12,
    S_JALR_LINK = 4'd13
  } state_e;

  localparam logic [6:0] OP_LW   = 7'd3;
  localparam logic [6:0] OP_SW   = 7'd35;
  localparam logic [6:0] OP_R    = 7'd51;
  localparam logic [6:0] OP_I    = 7'd19;
  localparam logic [6:0] OP_JAL  = 7'd111;
  localparam logic [6:0] OP_BR   = 7'd99;
  localparam logic [6:0] OP_LUI  = 7'd55;
  localparam logic [6:0] OP_JALR = 7'd103;

  state_e state_q;

  logic pc_write_c, ir_write_c, mem_write_c, reg_write_c;
  logic instr_done_c, illegal_c, branch_take_c;

  // State register and transitions; unused codes 14/15 recover to FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_q <= S_MEM_ADR;
            OP_R:         state_q <= S_EX_R;
            OP_I:         state_q <= S_EX_I;
            OP_JAL:       state_q <= S_JAL;
            OP_BR:        state_q <= S_BRANCH;
            OP_LUI:       state_q <= S_LUI;
            OP_JALR:      state_q <= S_JALR;
            default:      state_q <= S_FETCH;
          endcase
        end
        S_MEM_ADR:   state_q <= (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  state_q <= S_MEM_WB;
        S_EX_R:      state_q <= S_ALU_WB;
        S_EX_I:      state_q <= S_ALU_WB;
        S_JAL:       state_q <= S_ALU_WB;
        S_JALR:      state_q <= S_JALR_LINK;
        default:     state_q <= S_FETCH;
      endcase
    end
  end

  // beq takes on zero, bne on not-zero; other funct3 never redirect
  assign branch_take_c = ((f3 == 3'b000) & zero) | ((f3 == 3'b001) & ~zero);

  // State decode; zero/opcode only affect BRANCH, DECODE and MEM_ADR
  always_comb begin
    pc_write_c   = 1'b0;
    adr_src      = 1'b0;
    ir_write_c   = 1'b0;
    mem_write_c  = 1'b0;
    reg_write_c  = 1'b0;
    result_src   = 2'b00;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    imm_src      = 3'b000;
    alu_op       = 2'b00;
    instr_done_c = 1'b0;
    illegal_c    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write_c = 1'b1;
        pc_write_c = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (opcode == OP_JAL) ? 3'b011 : 3'b010;
        case (opcode)
          OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BR, OP_LUI, OP_JALR: illegal_c = 1'b0;
          default: illegal_c = 1'b1;
        endcase
        instr_done_c = illegal_c;
      end
      S_MEM_ADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (opcode == OP_LW) ? 3'b000 : 3'b001;
      end
      S_MEM_READ: adr_src = 1'b1;
      S_MEM_WB: begin
        result_src   = 2'b01;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
      end
      S_MEM_WRITE: begin
        adr_src      = 1'b1;
        mem_write_c  = 1'b1;
        instr_done_c = 1'b1;
      end
      S_EX_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EX_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
      end
      S_ALU_WB: begin
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write_c = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a    = 2'b10;
        alu_op       = 2'b01;
        pc_write_c   = branch_take_c;
        instr_done_c = 1'b1;
      end
      S_LUI: begin
        imm_src      = 3'b100;
        result_src   = 2'b11;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
      end
      S_JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write_c = 1'b1;
      end
      S_JALR_LINK: begin
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset masks every enable immediately, independent of the clock
  assign pc_write   = pc_write_c   & ~reset;
  assign ir_write   = ir_write_c   & ~reset;
  assign mem_write  = mem_write_c  & ~reset;
  assign reg_write  = reg_write_c  & ~reset;
  assign instr_done = instr_done_c & ~reset;
  assign illegal    = illegal_c    & ~reset;
  assign state      = state_q;

endmodule

// File: tb/tb_controller_multicycle.sv
// tb_controller_multicycle: directed instruction sequences; expected per-cycle
// control vectors are queued by the stimulus and checked by a monitor that
// pops one entry on every falling clock edge.
module tb_controller_multicycle;

  logic       clk, reset, zero;
  logic [6:0] opcode;
  logic [2:0] f3;
  logic       pc_write, adr_src, ir_write, mem_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_src;
  logic       instr_done, illegal;
  logic [3:0] state;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, irw, memw, regw;
    logic [1:0] rs, a, b;
    logic [2:0] imm;
    logic [1:0] aop;
    logic       done, ill;
  } exp_t;

  typedef struct {
    exp_t  e;
    string tag;
  } ent_t;

  ent_t q[$];
  ent_t mon_x;
  exp_t act;
  exp_t rst_vec;
  int   checks   = 0;
  int   failures = 0;

  controller_multicycle dut (
    .clk(clk), .reset(reset), .opcode(opcode), .f3(f3), .zero(zero),
    .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write),
    .mem_write(mem_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_op(alu_op), .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  assign act = {state, pc_write, adr_src, ir_write, mem_write, reg_write,
                result_src, alu_src_a, alu_src_b, imm_src, alu_op, instr_done, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written Moore values per state; context-dependent fields set by callers
  function automatic exp_t base(input logic [3:0] s);
    exp_t e;
    e    = '0;
    e.st = s;
    case (s)
      4'd0:  begin e.pcw = 1; e.irw = 1; e.b = 2'b10; e.rs = 2'b10; end
      4'd1:  begin e.a = 2'b01; e.b = 2'b01; end
      4'd2:  begin e.a = 2'b10; e.b = 2'b01; end
      4'd3:  begin e.adr = 1; end
      4'd4:  begin e.rs = 2'b01; e.regw = 1; e.done = 1; end
      4'd5:  begin e.adr = 1; e.memw = 1; e.done = 1; end
      4'd6:  begin e.a = 2'b10; e.aop = 2'b10; end
      4'd7:  begin e.a = 2'b10; e.b = 2'b01; e.aop = 2'b11; end
      4'd8:  begin e.regw = 1; e.done = 1; end
      4'd9:  begin e.a = 2'b01; e.b = 2'b10; e.pcw = 1; end
      4'd10: begin e.a = 2'b10; e.aop = 2'b01; e.done = 1; end
      4'd11: begin e.imm = 3'b100; e.rs = 2'b11; e.regw = 1; e.done = 1; end
      4'd12: begin e.a = 2'b10; e.b = 2'b01; e.rs = 2'b10; e.pcw = 1; end
      4'd13: begin e.a = 2'b01; e.b = 2'b10; e.rs = 2'b10; e.regw = 1; e.done = 1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic push(input exp_t e, input string tag);
    ent_t x;
    x.e   = e;
    x.tag = tag;
    q.push_back(x);
  endtask

  task automatic push_st(input logic [3:0] s, input string tag);
    push(base(s), tag);
  endtask

  task automatic push_imm(input logic [3:0] s, input logic [2:0] imm, input string tag);
    exp_t e;
    e     = base(s);
    e.imm = imm;
    push(e, tag);
  endtask

  task automatic run(input logic [6:0] op, input logic [2:0] f, input logic z, input int n);
    opcode = op;
    f3     = f;
    zero   = z;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_branch(input logic [2:0] f, input logic z, input logic pcw, input string tag);
    exp_t e;
    push_st(4'd0, tag);
    push_imm(4'd1, 3'b010, tag);
    e     = base(4'd10);
    e.pcw = pcw;
    push(e, tag);
    run(7'd99, f, z, 3);
  endtask

  // Monitor: every cycle with a queued expectation is compared
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_x = q.pop_front();
      checks++;
      if (act !== mon_x.e) begin
        failures++;
        $display("FAIL %s: got st=%0d vec=%h expected st=%0d vec=%h",
                 mon_x.tag, act.st, act, mon_x.e.st, mon_x.e);
      end
    end
  end

  initial begin
    exp_t e;
    rst_vec     = base(4'd0);
    rst_vec.pcw = 1'b0;
    rst_vec.irw = 1'b0;

    reset  = 1'b1;
    opcode = 7'd0;
    f3     = 3'd0;
    zero   = 1'b0;
    push(rst_vec, "rst_init");
    push(rst_vec, "rst_init");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // lw
    push_st(4'd0, "lw"); push_imm(4'd1, 3'b010, "lw"); push_imm(4'd2, 3'b000, "lw");
    push_st(4'd3, "lw"); push_st(4'd4, "lw");
    run(7'd3, 3'b010, 1'b1, 5);

    // sw
    push_st(4'd0, "sw"); push_imm(4'd1, 3'b010, "sw"); push_imm(4'd2, 3'b001, "sw");
    push_st(4'd5, "sw");
    run(7'd35, 3'b010, 1'b0, 4);

    // branches
    do_branch(3'b000, 1'b1, 1'b1, "beq_z1");
    do_branch(3'b000, 1'b0, 1'b0, "beq_z0");
    do_branch(3'b001, 1'b1, 1'b0, "bne_z1");
    do_branch(3'b001, 1'b0, 1'b1, "bne_z0");
    do_branch(3'b100, 1'b1, 1'b0, "blt_z1");
    do_branch(3'b100, 1'b0, 1'b0, "blt_z0");

    // jalr then jal
    push_st(4'd0, "jalr"); push_imm(4'd1, 3'b010, "jalr"); push_st(4'd12, "jalr");
    push_st(4'd13, "jalr");
    run(7'd103, 3'b000, 1'b0, 4);
    push_st(4'd0, "jal"); push_imm(4'd1, 3'b011, "jal"); push_st(4'd9, "jal");
    push_st(4'd8, "jal");
    run(7'd111, 3'b000, 1'b1, 4);

    // illegal opcode
    push_st(4'd0, "illegal");
    e      = base(4'd1);
    e.imm  = 3'b010;
    e.ill  = 1'b1;
    e.done = 1'b1;
    push(e, "illegal");
    run(7'h7F, 3'b000, 1'b0, 2);

    // R then lui back to back, then I-ALU
    push_st(4'd0, "rtype"); push_imm(4'd1, 3'b010, "rtype"); push_st(4'd6, "rtype");
    push_st(4'd8, "rtype");
    run(7'd51, 3'b000, 1'b0, 4);
    push_st(4'd0, "lui"); push_imm(4'd1, 3'b010, "lui"); push_st(4'd11, "lui");
    run(7'd55, 3'b000, 1'b0, 3);
    push_st(4'd0, "itype"); push_imm(4'd1, 3'b010, "itype"); push_st(4'd7, "itype");
    push_st(4'd8, "itype");
    run(7'd19, 3'b000, 1'b1, 4);

    // lw abandoned by reset while in MEM_READ
    push_st(4'd0, "lw_abort"); push_imm(4'd1, 3'b010, "lw_abort");
    push_imm(4'd2, 3'b000, "lw_abort"); push_st(4'd3, "lw_abort");
    opcode = 7'd3;
    f3     = 3'b010;
    zero   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (act !== rst_vec) begin
      failures++;
      $display("FAIL rst_immediate: got st=%0d vec=%h expected st=%0d vec=%h",
               act.st, act, rst_vec.st, rst_vec);
    end
    push(rst_vec, "rst_mid");
    push(rst_vec, "rst_mid");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // recovery after reset
    push_st(4'd0, "rtype_post"); push_imm(4'd1, 3'b010, "rtype_post");
    push_st(4'd6, "rtype_post"); push_st(4'd8, "rtype_post");
    run(7'd51, 3'b000, 1'b1, 4);
    push_st(4'd0, "lui_post"); push_imm(4'd1, 3'b010, "lui_post"); push_st(4'd11, "lui_post");
    run(7'd55, 3'b000, 1'b0, 3);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
